// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared state enum, access-direction constants and default widths for mem_responder
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  localparam int DEF_ADDR_W      = 8;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_WAIT_CYCLES = 1;

endpackage

// File: rtl/sp_ram.sv
// rtl/sp_ram.sv - single-port synchronous word array with write enable and registered read
module sp_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  // Contents are deliberately never reset.
  logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        r_mem[i_addr] <= i_wdata;
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - request/ack memory responder with fixed wait states; optional MEM_ALIGN_CHECK_EN
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              memRW,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ack,
  output logic              busy,
  output logic              err
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
  localparam logic       ZERO_WAIT = (WAIT_CYCLES == 0);

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_idx;
  logic              r_wr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_ack;
  logic              r_err;
  logic              r_rd_ok;

  logic              w_accept;
  logic              w_go_resp;
  logic              w_from_idle;
  logic [ADDR_W-1:0] w_acc_idx;
  logic              w_acc_wr;
  logic [DATA_W-1:0] w_acc_wdata;
  logic              w_acc_mis;
  logic              w_ram_en;
  logic [DATA_W-1:0] w_ram_rdata;
  logic              w_unused_addr;

  assign w_from_idle = (r_state == IDLE);
  assign w_accept    = w_from_idle && req;
  assign w_go_resp   = (w_accept && ZERO_WAIT) || (r_state == WAIT && r_cnt == 4'd1);

  // With zero wait states the access happens on the accept edge, so bypass the latches.
  assign w_acc_idx   = w_from_idle ? addr[ADDR_W+1:2] : r_idx;
  assign w_acc_wr    = w_from_idle ? memRW : r_wr;
  assign w_acc_wdata = w_from_idle ? wdata : r_wdata;

`ifdef MEM_ALIGN_CHECK_EN
  logic r_mis;
  assign w_acc_mis = w_from_idle ? (addr[1:0] != 2'b00) : r_mis;
  always_ff @(posedge clk) begin
    if (!rst && w_accept) begin
      r_mis <= (addr[1:0] != 2'b00);
    end
  end
`else
  assign w_acc_mis = 1'b0;
`endif

  assign w_unused_addr = ^{addr[31:ADDR_W+2], addr[1:0]};

  // Reset on the commit edge must drop the access, hence the rst gate.
  assign w_ram_en = w_go_resp && !rst && !w_acc_mis;

  sp_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (clk),
    .i_en    (w_ram_en),
    .i_we    (w_acc_wr == MEM_WRITE),
    .i_addr  (w_acc_idx),
    .i_wdata (w_acc_wdata),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst && w_accept) begin
      r_idx   <= addr[ADDR_W+1:2];
      r_wr    <= memRW;
      r_wdata <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_rd_ok <= 1'b0;
    end else begin
      r_ack   <= w_go_resp;
      r_err   <= w_go_resp && w_acc_mis;
      r_rd_ok <= w_go_resp && (w_acc_wr == MEM_READ) && !w_acc_mis;
      case (r_state)
        IDLE: begin
          if (req) begin
            r_cnt   <= WAIT_INIT;
            r_state <= ZERO_WAIT ? RESP : WAIT;
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= RESP;
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ack   = r_ack;
  assign busy  = (r_state != IDLE);
  assign rdata = r_rd_ok ? w_ram_rdata : '0;
`ifdef MEM_ALIGN_CHECK_EN
  assign err   = r_err;
`else
  assign err   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - randomized self-checking bench for mem_responder at wait states 1, 0 and 3
module tb_mem_responder;

  localparam int N_DUT  = 3;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 1 << ADDR_W;

  function automatic int wait_of(input int d);
    return (d == 0) ? 1 : ((d == 1) ? 0 : 3);
  endfunction

  logic              clk = 1'b0;
  logic              rst;
  logic              req_s   [N_DUT];
  logic              rw_s    [N_DUT];
  logic [31:0]       addr_s  [N_DUT];
  logic [DATA_W-1:0] wdata_s [N_DUT];
  logic [DATA_W-1:0] rdata_s [N_DUT];
  logic              ack_s   [N_DUT];
  logic              busy_s  [N_DUT];
  logic              err_s   [N_DUT];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    mem_responder #(
      .ADDR_W      (ADDR_W),
      .DATA_W      (DATA_W),
      .WAIT_CYCLES (wait_of(g))
    ) u_dut (
      .clk   (clk),
      .rst   (rst),
      .req   (req_s[g]),
      .memRW (rw_s[g]),
      .addr  (addr_s[g]),
      .wdata (wdata_s[g]),
      .rdata (rdata_s[g]),
      .ack   (ack_s[g]),
      .busy  (busy_s[g]),
      .err   (err_s[g])
    );
  end

  logic [31:0] model [N_DUT][DEPTH];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the ack cycle.
  task automatic txn(input int d, input bit wr, input logic [31:0] a,
                     input logic [31:0] wd, input bit pulses);
    int          idx;
    bit          mis;
    logic [31:0] exp_rd;
    int          lat;
    bit          busy_ok;
    idx = int'(a[ADDR_W+1:2]);
    mis = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    mis = (a[1:0] != 2'b00);
`endif
    exp_rd = (wr || mis) ? 32'h0 : model[d][idx];
    if (wr && !mis) model[d][idx] = wd;
    req_s[d] = 1'b1; rw_s[d] = wr; addr_s[d] = a; wdata_s[d] = wd;
    @(posedge clk);
    lat = 0;
    busy_ok = 1'b1;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(negedge clk);
      if (busy_s[d] !== 1'b1) busy_ok = 1'b0;
      if (ack_s[d] === 1'b1) begin
        lat = k;
        check_eq($sformatf("d%0d rdata a=%h", d, a), rdata_s[d], exp_rd);
        check_eq($sformatf("d%0d err a=%h", d, a), {31'b0, err_s[d]}, {31'b0, mis});
      end
      req_s[d]   = pulses ? 1'($urandom_range(0, 1)) : 1'b0;
      rw_s[d]    = 1'($urandom_range(0, 1));
      addr_s[d]  = $urandom;
      wdata_s[d] = $urandom;
    end
    check_eq($sformatf("d%0d latency", d), lat, 1 + wait_of(d));
    check_eq($sformatf("d%0d busy", d), {31'b0, busy_ok}, 32'd1);
    @(negedge clk);
    req_s[d] = 1'b0;
    check_eq($sformatf("d%0d post ack/busy", d), {30'b0, ack_s[d], busy_s[d]}, 32'd0);
  endtask

  task automatic count_acks(input int d, input int cycles, output int n);
    n = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (ack_s[d] !== 1'b0 || busy_s[d] !== 1'b0) n++;
    end
  endtask

  // Reset lands in WAIT of a write; the write must be dropped.
  task automatic rst_in_wait(input int d, input int depth);
    int n;
    req_s[d] = 1'b1; rw_s[d] = 1'b1; addr_s[d] = 32'h20; wdata_s[d] = 32'hCAFEF00D;
    @(posedge clk);
    for (int k = 0; k < depth; k++) begin
      @(negedge clk);
      req_s[d] = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    count_acks(d, 6, n);
    check_eq($sformatf("d%0d rst-in-wait acks", d), n, 0);
    txn(d, 1'b0, 32'h20, 32'h0, 1'b0);
  endtask

  int          n_bad;
  bit          wr;
  logic [31:0] a;

  initial begin
    rst = 1'b1;
    for (int d = 0; d < N_DUT; d++) begin
      req_s[d] = 1'b0; rw_s[d] = 1'b0; addr_s[d] = '0; wdata_s[d] = '0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      for (int d = 0; d < N_DUT; d++) begin
        check_eq($sformatf("d%0d reset outs", d), {29'b0, ack_s[d], busy_s[d], err_s[d]}, 32'd0);
        check_eq($sformatf("d%0d reset rdata", d), rdata_s[d], 32'd0);
      end
    end

    for (int d = 0; d < N_DUT; d++) begin
      for (int i = 0; i < DEPTH; i++) begin
        a = {$urandom_range(0, 255) , 24'h0} | (32'(i) << 2);
        txn(d, 1'b1, a, $urandom, 1'b0);
      end
      txn(d, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
      txn(d, 1'b0, 32'h10, 32'h0, 1'b1);
      txn(d, 1'b1, 32'h404, 32'h12345678, 1'b1);
      txn(d, 1'b0, 32'h004, 32'h0, 1'b1);
`ifdef MEM_ALIGN_CHECK_EN
      txn(d, 1'b1, 32'h22, 32'h55AA55AA, 1'b0);
      txn(d, 1'b0, 32'h20, 32'h0, 1'b0);
`endif
      for (int t = 0; t < 150; t++) begin
        wr = 1'($urandom_range(0, 1));
        a  = $urandom;
        if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
        txn(d, wr, a, $urandom, 1'($urandom_range(0, 1)));
      end
    end

    rst_in_wait(0, 1);
    rst_in_wait(2, 1);
    rst_in_wait(2, 3);

    req_s[1] = 1'b1; rw_s[1] = 1'b1; addr_s[1] = 32'h20; wdata_s[1] = 32'h0BADF00D;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req_s[1] = 1'b0;
    count_acks(1, 4, n_bad);
    check_eq("d1 rst+req acks", n_bad, 0);
    txn(1, 1'b0, 32'h20, 32'h0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
